// File: rtl/color_picker_map.sv
// Registered colour-picker palette: cursor colour and per-pixel overlay colour, one-cycle latency.
// Optional build macro COLOR_PICKER_GRID_EN blanks cell-boundary pixels inside the palette.
module color_picker_map #(
  parameter int PIXLW    = 12,
  parameter int COLRW    = 4,
  parameter int CORDW    = 16,
  parameter int SIZE     = 128,
  parameter int CURSOR_R = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic [PIXLW-1:0] color,
  output logic [PIXLW-1:0] render
);

  localparam int L = $clog2(SIZE);
  localparam logic [CORDW-1:0] MAX_C = CORDW'(SIZE - 1);
  localparam logic signed [CORDW:0] ARM = (CORDW+1)'(CURSOR_R);

  // Interface: no valid/ready; a new coordinate set is accepted on every edge
  // and its results appear on color/render exactly one edge later.

  function automatic logic [PIXLW-1:0] palette(input logic [COLRW-1:0] u,
                                               input logic [COLRW-1:0] v);
    logic [COLRW:0] s;
    logic [COLRW:0] t;
    s = ({1'b0, u} + {1'b0, v}) >> 1;
    t = {1'b0, {COLRW{1'b1}}} - s;
    return {u, v, t[COLRW-1:0]};
  endfunction

  logic [CORDW-1:0]       xc, yc;
  logic signed [CORDW:0]  dx, dy, adx, ady;
  logic                   in_area, on_cross;
  logic [PIXLW-1:0]       pix;
  logic [PIXLW-1:0]       color_d, color_q;
  logic [PIXLW-1:0]       render_d, render_q;

  always_comb begin
    xc  = (x > MAX_C) ? MAX_C : x;
    yc  = (y > MAX_C) ? MAX_C : y;
    dx  = $signed({1'b0, sx}) - $signed({1'b0, xc});
    dy  = $signed({1'b0, sy}) - $signed({1'b0, yc});
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    in_area  = (sx <= MAX_C) && (sy <= MAX_C);
    on_cross = ((sx == xc) && (ady <= ARM)) || ((sy == yc) && (adx <= ARM));
    pix      = palette(sx[L-1 -: COLRW], sy[L-1 -: COLRW]);
    color_d  = palette(xc[L-1 -: COLRW], yc[L-1 -: COLRW]);

    render_d = '0;
    if (!in_area) begin
      render_d = '0;
    end else if (on_cross) begin
      render_d = ~pix;
`ifdef COLOR_PICKER_GRID_EN
    end else if ((sx[L-COLRW-1:0] == '0) || (sy[L-COLRW-1:0] == '0)) begin
      render_d = '0;
`endif
    end else begin
      render_d = pix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      color_q  <= '0;
      render_q <= '0;
    end else begin
      color_q  <= color_d;
      render_q <= render_d;
    end
  end

  assign color  = color_q;
  assign render = render_q;

endmodule

// File: tb/tb_color_picker_map.sv
// Directed and random checks of color_picker_map against a behavioural palette model.
module tb_color_picker_map;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x = '0, y = '0, sx = '0, sy = '0;
  logic [11:0] color, render;

  logic [11:0] exp_color_q[$];
  logic [11:0] exp_render_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  color_picker_map dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .sx(sx), .sy(sy),
    .color(color), .render(render)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [11:0] m_pal(input int px, input int py);
    int u, v, b;
    u = (px / 8) % 16;
    v = (py / 8) % 16;
    b = 15 - (u + v) / 2;
    return 12'((u << 8) | (v << 4) | b);
  endfunction

  function automatic logic [11:0] m_color(input int cx, input int cy);
    int xc, yc;
    xc = (cx > 127) ? 127 : cx;
    yc = (cy > 127) ? 127 : cy;
    return m_pal(xc, yc);
  endfunction

  function automatic logic [11:0] m_render(input int cx, input int cy, input int px, input int py);
    int xc, yc, ax, ay;
    xc = (cx > 127) ? 127 : cx;
    yc = (cy > 127) ? 127 : cy;
    ax = (px > xc) ? px - xc : xc - px;
    ay = (py > yc) ? py - yc : yc - py;
    if (px >= 128 || py >= 128) return 12'h000;
    if ((px == xc && ay <= 4) || (py == yc && ax <= 4)) return ~m_pal(px, py);
`ifdef COLOR_PICKER_GRID_EN
    if (px % 8 == 0 || py % 8 == 0) return 12'h000;
`endif
    return m_pal(px, py);
  endfunction

  // driver: apply one input set and push the expected outputs
  task automatic drive(input logic r, input int cx, input int cy, input int px, input int py,
                       input logic [11:0] ec, input logic [11:0] er);
    @(negedge clk);
    rst = r; x = 16'(cx); y = 16'(cy); sx = 16'(px); sy = 16'(py);
    exp_color_q.push_back(ec);
    exp_render_q.push_back(er);
  endtask

  // scoreboard: pop after the edge that registers the step
  task automatic check(input string tag);
    logic [11:0] ec, er;
    @(posedge clk);
    #1;
    ec = exp_color_q.pop_front();
    er = exp_render_q.pop_front();
    n_cmp++;
    assert (color === ec) else begin
      n_fail++;
      $error("FAIL %s color got=%h exp=%h", tag, color, ec);
    end
    n_cmp++;
    assert (render === er) else begin
      n_fail++;
      $error("FAIL %s render got=%h exp=%h", tag, render, er);
    end
  endtask

  task automatic step(input string tag, input int cx, input int cy, input int px, input int py);
    drive(1'b1, cx, cy, px, py, m_color(cx, cy), m_render(cx, cy, px, py));
    check(tag);
  endtask

  task automatic step_k(input string tag, input int cx, input int cy, input int px, input int py,
                        input logic [11:0] ec, input logic [11:0] er);
    drive(1'b1, cx, cy, px, py, ec, er);
    check(tag);
  endtask

  initial begin
    int cx, cy, px, py;
    logic [11:0] r69;
`ifdef COLOR_PICKER_GRID_EN
    r69 = 12'h000;
`else
    r69 = 12'h849;
`endif

    drive(1'b0, 64, 32, 0, 0, 12'h000, 12'h000); check("reset0");
    drive(1'b0, 64, 32, 0, 0, 12'h000, 12'h000); check("reset1");
    step_k("release", 64, 32, 0, 0, 12'h849, m_render(64, 32, 0, 0));

    step_k("c00", 0, 0, 10, 100, 12'h00F, 12'h1C9);
    step_k("c127", 127, 127, 10, 100, 12'hFF0, 12'h1C9);
    step_k("clamp", 300, 500, 10, 100, 12'hFF0, 12'h1C9);
    step_k("plain", 64, 32, 10, 100, 12'h849, 12'h1C9);
    step_k("varm", 64, 32, 64, 34, 12'h849, 12'h7B6);
    step_k("harm_end", 64, 32, 68, 32, 12'h849, 12'h7B6);
    step_k("harm_past", 64, 32, 69, 32, 12'h849, r69);
    step_k("harm_neg", 64, 32, 60, 32, 12'h849, ~m_pal(60, 32));
    step_k("vneg_past", 64, 32, 64, 27, 12'h849, m_render(64, 32, 64, 27));
    step_k("oob_x", 64, 32, 200, 10, 12'h849, 12'h000);
    step_k("oob_wrap", 64, 32, 16'hFFF0, 5, 12'h849, 12'h000);
    step_k("oob_edge", 64, 32, 128, 127, 12'h849, 12'h000);
`ifdef COLOR_PICKER_GRID_EN
    step_k("grid", 64, 32, 16, 100, 12'h849, 12'h000);
`else
    step_k("grid", 64, 32, 16, 100, 12'h849, 12'h2C8);
`endif
    step("corner_cross", 300, 300, 127, 125);

    // mid-stream reset zeroes outputs, then operation resumes
    drive(1'b0, 127, 127, 10, 100, 12'h000, 12'h000); check("midreset");
    step_k("resume", 127, 127, 10, 100, 12'hFF0, 12'h1C9);

    // back-to-back pipelined stream: drive next before checking previous
    drive(1'b1, 0, 0, 10, 100, 12'h00F, 12'h1C9);
    for (int i = 0; i < 40; i++) begin
      cx = $urandom_range(0, 200);
      cy = $urandom_range(0, 200);
      if ($urandom_range(0, 1) == 1) begin
        px = ((cx > 127) ? 127 : cx) + $urandom_range(0, 12) - 6;
        py = ((cy > 127) ? 127 : cy);
        if ($urandom_range(0, 1) == 1) begin
          py = px; px = ((cx > 127) ? 127 : cx);
          py = ((cy > 127) ? 127 : cy) + $urandom_range(0, 12) - 6;
        end
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 140);
        py = $urandom_range(0, 140);
      end
      fork
        drive(1'b1, cx, cy, px, py, m_color(cx, cy), m_render(cx, cy, px, py));
        check("rand");
      join
    end
    check("rand_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
